// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two issue ports, the response consumer and alu_arbiter.
// The arbiter takes the slave modport; the requester/consumer side takes master.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ack;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req0_cin;
  logic             req1_cin;
  logic [3:0]       req0_ctrl;
  logic [3:0]       req1_ctrl;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_res;
  logic             rsp_cout;
  logic             rsp_err;

  modport slave (
    input  req_valid, req0_a, req0_b, req1_a, req1_b,
           req0_cin, req1_cin, req0_ctrl, req1_ctrl, rsp_ready,
    output req_ack, rsp_valid, rsp_id, rsp_res, rsp_cout, rsp_err
  );

  modport master (
    output req_valid, req0_a, req0_b, req1_a, req1_b,
           req0_cin, req1_cin, req0_ctrl, req1_ctrl, rsp_ready,
    input  req_ack, rsp_valid, rsp_id, rsp_res, rsp_cout, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters:
// registers the winner's operands, captures the result a cycle later, holds it until accepted.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  alu_arbiter_if.slave      bus,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic              alu_cin,
  output logic [3:0]        alu_ctrl,
  input  logic [WIDTH-1:0]  alu_res,
  input  logic              alu_cout,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_SRL = 4'b1000;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             alu_cin_q, alu_cin_d;
  logic [3:0]       alu_ctrl_q, alu_ctrl_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_res_q, rsp_res_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             rsp_err_q, rsp_err_d;
  logic [1:0]       ack;
  logic             grant;
  logic             legal_op;

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_cin_d  = alu_cin_q;
    alu_ctrl_d = alu_ctrl_q;
    rsp_id_d   = rsp_id_q;
    rsp_res_d  = rsp_res_q;
    rsp_cout_d = rsp_cout_q;
    rsp_err_d  = rsp_err_q;
    ack        = 2'b00;
    grant      = 1'b0;
    legal_op   = (alu_ctrl_q <= OP_SRL);

    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          // On a tie the prio bit decides; otherwise the lone requester wins.
          grant      = (&bus.req_valid) ? prio_q : bus.req_valid[1];
          ack[grant] = 1'b1;
          rsp_id_d   = grant;
          state_d    = EXEC;
          if (grant) begin
            alu_a_d    = bus.req1_a;
            alu_b_d    = bus.req1_b;
            alu_cin_d  = bus.req1_cin;
            alu_ctrl_d = bus.req1_ctrl;
          end else begin
            alu_a_d    = bus.req0_a;
            alu_b_d    = bus.req0_b;
            alu_cin_d  = bus.req0_cin;
            alu_ctrl_d = bus.req0_ctrl;
          end
        end
      end
      EXEC: begin
        // Illegal opcodes still take the EXEC slot but report zero result and an error.
        rsp_res_d  = legal_op ? alu_res : '0;
        rsp_cout_d = ((alu_ctrl_q == OP_ADD) || (alu_ctrl_q == OP_SUB)) ? alu_cout : 1'b0;
        rsp_err_d  = !legal_op;
        state_d    = DONE;
      end
      DONE: begin
        if (bus.rsp_ready) begin
          prio_d  = !rsp_id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_cin_q  <= 1'b0;
      alu_ctrl_q <= 4'b0000;
      rsp_id_q   <= 1'b0;
      rsp_res_q  <= '0;
      rsp_cout_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_cin_q  <= alu_cin_d;
      alu_ctrl_q <= alu_ctrl_d;
      rsp_id_q   <= rsp_id_d;
      rsp_res_q  <= rsp_res_d;
      rsp_cout_q <= rsp_cout_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign bus.req_ack   = ack;
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_res   = rsp_res_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_err   = rsp_err_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_cin       = alu_cin_q;
  assign alu_ctrl      = alu_ctrl_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: table of single ops, hand-written multi-cycle sequences,
// and a scoreboard that predicts every response at ack time.
module tb_alu_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] alu_a, alu_b, alu_res;
  logic        alu_cin, alu_cout, busy;
  logic [3:0]  alu_ctrl;

  alu_arbiter_if #(.WIDTH(32)) bus ();

  alu_arbiter #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_cin  (alu_cin),
    .alu_ctrl (alu_ctrl),
    .alu_res  (alu_res),
    .alu_cout (alu_cout),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU; drives junk carry/result where the arbiter must mask them.
  always_comb begin
    alu_res  = 32'hDEADBEEF;
    alu_cout = 1'b1;
    case (alu_ctrl)
      4'b0000: {alu_cout, alu_res} = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_cin};
      4'b0001: {alu_cout, alu_res} = {1'b0, alu_a} - {1'b0, alu_b} - {32'd0, alu_cin};
      4'b0010: alu_res = alu_a & alu_b;
      4'b0011: alu_res = alu_a | alu_b;
      4'b0100: alu_res = alu_a ^ alu_b;
      4'b0101: alu_res = ~alu_a;
      4'b0110: alu_res = alu_a << alu_b[4:0];
      4'b0111: alu_res = $signed(alu_a) >>> alu_b[4:0];
      4'b1000: alu_res = alu_a >> alu_b[4:0];
      default: ;
    endcase
  end

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        cout;
    logic        err;
  } exp_t;

  typedef struct {
    logic        sel;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] exp_res;
    logic        exp_cout;
    logic        exp_err;
  } vector_t;

  exp_t sb_q[$];
  int   n_compared = 0;
  int   n_mismatched = 0;

  function automatic exp_t predict(logic id, logic [3:0] ctrl, logic [31:0] a, logic [31:0] b, logic cin);
    exp_t e;
    logic [32:0] wide;
    e.id = id; e.res = 32'd0; e.cout = 1'b0; e.err = 1'b0;
    case (ctrl)
      4'b0000: begin wide = {1'b0, a} + {1'b0, b} + {32'd0, cin}; e.res = wide[31:0]; e.cout = wide[32]; end
      4'b0001: begin wide = {1'b0, a} - {1'b0, b} - {32'd0, cin}; e.res = wide[31:0]; e.cout = wide[32]; end
      4'b0010: e.res = a & b;
      4'b0011: e.res = a | b;
      4'b0100: e.res = a ^ b;
      4'b0101: e.res = ~a;
      4'b0110: e.res = a << b[4:0];
      4'b0111: e.res = $signed(a) >>> b[4:0];
      4'b1000: e.res = a >> b[4:0];
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic sel, input logic [3:0] ctrl, input logic [31:0] a,
                               input logic [31:0] b, input logic cin);
    if (sel) begin
      bus.req1_ctrl = ctrl; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin;
      bus.req_valid[1] = 1'b1;
    end else begin
      bus.req0_ctrl = ctrl; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin;
      bus.req_valid[0] = 1'b1;
    end
  endtask

  // Scoreboard: predict at ack, compare at the response handshake.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.req_ack != 2'b00) begin
        checkOutput("ack_onehot", {31'd0, $onehot(bus.req_ack)}, 32'd1);
        if (bus.req_ack[1])
          sb_q.push_back(predict(1'b1, bus.req1_ctrl, bus.req1_a, bus.req1_b, bus.req1_cin));
        else
          sb_q.push_back(predict(1'b0, bus.req0_ctrl, bus.req0_a, bus.req0_b, bus.req0_cin));
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb_q.size() == 0) begin
          checkOutput("sb_unexpected_rsp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          checkOutput("sb_id", {31'd0, bus.rsp_id}, {31'd0, e.id});
          checkOutput("sb_res", bus.rsp_res, e.res);
          checkOutput("sb_cout", {31'd0, bus.rsp_cout}, {31'd0, e.cout});
          checkOutput("sb_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
        end
      end
    end
  end

  vector_t vecs[13];

  initial begin
    logic [1:0] acked;
    logic       exp_id;
    int         seen;

    vecs[0]  = '{1'b0, 4'b0000, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 4'b0000, 32'd5,        32'd7,        1'b1, 32'd13,        1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'b0001, 32'd10,       32'd3,        1'b0, 32'd7,         1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'b0001, 32'd3,        32'd10,       1'b0, 32'hFFFFFFF9,  1'b1, 1'b0};
    vecs[4]  = '{1'b0, 4'b0010, 32'h0000F0F0, 32'h0000FF00, 1'b0, 32'h0000F000,  1'b0, 1'b0};
    vecs[5]  = '{1'b1, 4'b0011, 32'h0000F0F0, 32'h00000F0F, 1'b0, 32'h0000FFFF,  1'b0, 1'b0};
    vecs[6]  = '{1'b0, 4'b0100, 32'hFFFF0000, 32'hFF00FF00, 1'b0, 32'h00FFFF00,  1'b0, 1'b0};
    vecs[7]  = '{1'b1, 4'b0101, 32'h0000FFFF, 32'h00000000, 1'b0, 32'hFFFF0000,  1'b0, 1'b0};
    vecs[8]  = '{1'b0, 4'b0110, 32'h00000001, 32'd4,        1'b0, 32'h00000010,  1'b0, 1'b0};
    vecs[9]  = '{1'b1, 4'b0111, 32'h80000000, 32'd4,        1'b0, 32'hF8000000,  1'b0, 1'b0};
    vecs[10] = '{1'b0, 4'b1000, 32'h80000000, 32'd4,        1'b0, 32'h08000000,  1'b0, 1'b0};
    vecs[11] = '{1'b1, 4'b1111, 32'h12345678, 32'h9ABCDEF0, 1'b1, 32'h00000000,  1'b0, 1'b1};
    vecs[12] = '{1'b0, 4'b1001, 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'h00000000,  1'b0, 1'b1};

    reset = 1'b1;
    bus.req_valid = 2'b00; bus.rsp_ready = 1'b1;
    bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 1'b0; bus.req0_ctrl = '0;
    bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 1'b0; bus.req1_ctrl = '0;
    tick();
    tick();
    @(negedge clk);
    checkOutput("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_alu_a", alu_a, 32'd0);
    checkOutput("rst_rsp_res", bus.rsp_res, 32'd0);
    tick();
    reset = 1'b0;

    // Single ops at full throughput: ack in N, rsp_valid in N+2, next op in N+3.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].sel, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].cin);
      @(negedge clk);
      checkOutput($sformatf("v%0d_ack", i), {30'd0, bus.req_ack}, vecs[i].sel ? 32'd2 : 32'd1);
      tick();
      bus.req_valid = 2'b00;
      @(negedge clk);
      checkOutput($sformatf("v%0d_exec_valid", i), {31'd0, bus.rsp_valid}, 32'd0);
      checkOutput($sformatf("v%0d_exec_busy", i), {31'd0, busy}, 32'd1);
      tick();
      @(negedge clk);
      checkOutput($sformatf("v%0d_valid", i), {31'd0, bus.rsp_valid}, 32'd1);
      checkOutput($sformatf("v%0d_id", i), {31'd0, bus.rsp_id}, {31'd0, vecs[i].sel});
      checkOutput($sformatf("v%0d_res", i), bus.rsp_res, vecs[i].exp_res);
      checkOutput($sformatf("v%0d_cout", i), {31'd0, bus.rsp_cout}, {31'd0, vecs[i].exp_cout});
      checkOutput($sformatf("v%0d_err", i), {31'd0, bus.rsp_err}, {31'd0, vecs[i].exp_err});
      tick();
    end

    // Tie right after reset: requester 0 first, requester 1 three cycles later.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 4'b0001, 32'd10, 32'd3, 1'b0);
    applyStimulus(1'b1, 4'b0010, 32'h0000F0F0, 32'h0000FF00, 1'b0);
    @(negedge clk);
    checkOutput("tie_ack0", {30'd0, bus.req_ack}, 32'd1);
    tick();
    bus.req_valid[0] = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("tie_res0", bus.rsp_res, 32'd7);
    checkOutput("tie_done_ack", {30'd0, bus.req_ack}, 32'd0);
    tick();
    @(negedge clk);
    checkOutput("tie_ack1", {30'd0, bus.req_ack}, 32'd2);
    tick();
    bus.req_valid = 2'b00;
    tick();
    @(negedge clk);
    checkOutput("tie_res1", bus.rsp_res, 32'h0000F000);
    checkOutput("tie_cout1", {31'd0, bus.rsp_cout}, 32'd0);
    tick();

    // Both held valid: responses must alternate 0,1,0,1.
    applyStimulus(1'b0, 4'b0000, $urandom, $urandom, 1'b0);
    applyStimulus(1'b1, 4'b0001, $urandom, $urandom, 1'b1);
    exp_id = 1'b0;
    seen = 0;
    for (int cyc = 0; cyc < 40 && seen < 4; cyc++) begin
      @(negedge clk);
      acked = bus.req_ack;
      if (bus.rsp_valid && bus.rsp_ready) begin
        checkOutput($sformatf("rr_id%0d", seen), {31'd0, bus.rsp_id}, {31'd0, exp_id});
        exp_id = ~exp_id;
        seen++;
      end
      tick();
      if (acked[0]) begin bus.req0_a = $urandom; bus.req0_b = $urandom; end
      if (acked[1]) begin bus.req1_a = $urandom; bus.req1_b = $urandom; end
    end
    bus.req_valid = 2'b00;
    checkOutput("rr_count", seen, 32'd4);
    tick();

    // Back-pressure: DONE holds for 5 cycles, no ack; pending request acked only after.
    bus.rsp_ready = 1'b0;
    applyStimulus(1'b0, 4'b0000, 32'd100, 32'd23, 1'b0);
    @(negedge clk);
    checkOutput("bp_ack0", {30'd0, bus.req_ack}, 32'd1);
    tick();
    bus.req_valid = 2'b00;
    applyStimulus(1'b1, 4'b0010, 32'd3, 32'd5, 1'b0);
    @(negedge clk);
    checkOutput("bp_exec_ack", {30'd0, bus.req_ack}, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_valid%0d", i), {31'd0, bus.rsp_valid}, 32'd1);
      checkOutput($sformatf("bp_res%0d", i), bus.rsp_res, 32'd123);
      checkOutput($sformatf("bp_id%0d", i), {31'd0, bus.rsp_id}, 32'd0);
      checkOutput($sformatf("bp_cout%0d", i), {31'd0, bus.rsp_cout}, 32'd0);
      checkOutput($sformatf("bp_ack%0d", i), {30'd0, bus.req_ack}, 32'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_valid", {31'd0, bus.rsp_valid}, 32'd1);
    checkOutput("bp_release_ack", {30'd0, bus.req_ack}, 32'd0);
    tick();
    @(negedge clk);
    checkOutput("bp_idle_valid", {31'd0, bus.rsp_valid}, 32'd0);
    checkOutput("bp_idle_ack", {30'd0, bus.req_ack}, 32'd2);
    tick();
    bus.req_valid = 2'b00;
    tick();
    @(negedge clk);
    checkOutput("bp_next_res", bus.rsp_res, 32'd1);
    checkOutput("bp_next_id", {31'd0, bus.rsp_id}, 32'd1);
    tick();

    // Reset while in EXEC drops the operation entirely.
    applyStimulus(1'b0, 4'b0000, 32'd1, 32'd2, 1'b0);
    @(negedge clk);
    checkOutput("rm_ack", {30'd0, bus.req_ack}, 32'd1);
    tick();
    bus.req_valid = 2'b00;
    reset = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("rm_valid", {31'd0, bus.rsp_valid}, 32'd0);
    checkOutput("rm_busy", {31'd0, busy}, 32'd0);
    checkOutput("rm_alu_a", alu_a, 32'd0);
    checkOutput("rm_alu_b", alu_b, 32'd0);
    checkOutput("rm_alu_cin", {31'd0, alu_cin}, 32'd0);
    checkOutput("rm_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    checkOutput("rm_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
    checkOutput("rm_rsp_res", bus.rsp_res, 32'd0);
    checkOutput("rm_rsp_cout", {31'd0, bus.rsp_cout}, 32'd0);
    checkOutput("rm_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    tick();
    reset = 1'b0;
    sb_q.delete();
    applyStimulus(1'b1, 4'b0100, 32'h000000A5, 32'h0000000F, 1'b0);
    @(negedge clk);
    checkOutput("rm_new_ack", {30'd0, bus.req_ack}, 32'd2);
    tick();
    bus.req_valid = 2'b00;
    tick();
    @(negedge clk);
    checkOutput("rm_new_valid", {31'd0, bus.rsp_valid}, 32'd1);
    checkOutput("rm_new_res", bus.rsp_res, 32'h000000AA);
    checkOutput("rm_new_id", {31'd0, bus.rsp_id}, 32'd1);
    tick();
    tick();

    checkOutput("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
